// File: rtl/rom_cmd_pkg.sv
// ----------------------------------------------------------------------------
// rom_cmd_pkg
//   Shared definitions for the ROM command engine: command opcodes, response
//   header bytes and the engine's FSM state type.
// ----------------------------------------------------------------------------
package rom_cmd_pkg;

    // Command opcodes (first byte of every frame)
    localparam logic [7:0] OPC_READ    = 8'h01;
    localparam logic [7:0] OPC_PING    = 8'h02;

    // Response header / status bytes
    localparam logic [7:0] RSP_READ_OK = 8'hA1;
    localparam logic [7:0] RSP_PING    = 8'hA2;
    localparam logic [7:0] RSP_ERR     = 8'hEE;

    // Engine states. HDR, SEND, PING_RSP and ERR are the push states; they
    // are the only states that drive res_wr_en.
    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_CHECK,
        S_HDR,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_PING_RSP,
        S_ERR
    } state_e;

endpackage : rom_cmd_pkg

// File: rtl/rom_cmd_engine.sv
// ----------------------------------------------------------------------------
// rom_cmd_engine
//   Command interpreter between a byte-wide command FIFO (read side) and a
//   byte-wide response FIFO (write side). Parses framed READ/PING commands,
//   reads 64-bit words from a synchronous ROM and streams the requested bytes,
//   preceded by a status header, into the response FIFO.
//
//   Frames:    PING = 02
//              READ = 01, A[7:0], A[15:8], A[23:16], A[31:24], LEN (0 = 256)
//   Responses: PING -> A2 ; READ ok -> A1 + LEN bytes ; error -> EE
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cmd_empty     command FIFO empty
//   cmd_din       command FIFO head byte (first-word-fall-through)
//   cmd_rd_en     pop command byte (consumed in the same cycle)
//   res_full      response FIFO full
//   res_wr_en     push res_dout into the response FIFO
//   res_dout      response byte (held while stalled)
//   rom_en        ROM read strobe
//   rom_addr      ROM word address
//   rom_rdata     ROM data, valid the cycle after rom_en
//   busy          engine is not in IDLE
// ----------------------------------------------------------------------------
module rom_cmd_engine
    import rom_cmd_pkg::*;
#(
    parameter int ROM_AW = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_empty,
    input  logic [7:0]        cmd_din,
    output logic              cmd_rd_en,
    input  logic              res_full,
    output logic              res_wr_en,
    output logic [7:0]        res_dout,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              busy
);

    // The byte-lane mux assumes exactly eight lanes per ROM word.
    if (DATA_W != 64) begin : g_bad_data_w
        $error("rom_cmd_engine: DATA_W must be 64");
    end

    // Total ROM size in bytes, held in 33 bits to match the end-of-range sum.
    localparam logic [32:0] ROM_BYTES = 33'd1 << (ROM_AW + 3);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [31:0]         addr_q,  addr_d;    // current byte address
    logic [8:0]          cnt_q,   cnt_d;     // bytes still to send (1..256)
    logic [1:0]          idx_q,   idx_d;     // address byte position in ADDR
    logic [DATA_W-1:0]   word_q,  word_d;    // latched ROM word

    logic [32:0]         addr_end;           // addr + len, never wraps
    logic [7:0]          lane_byte;          // lane addr[2:0] of word_q

    // Lane k of the latched word is bits 8k+7:8k.
    assign lane_byte = word_q[{addr_q[2:0], 3'b000} +: 8];

    // Zero-extended sum; anything above ROM_BYTES (including non-zero high
    // address bits) is out of range.
    assign addr_end = {1'b0, addr_q} + {24'd0, cnt_q};

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        word_d    = word_q;
        cmd_rd_en = 1'b0;
        res_wr_en = 1'b0;
        res_dout  = 8'h00;
        rom_en    = 1'b0;
        rom_addr  = '0;

        unique case (state_q)
            S_IDLE: begin
                cmd_rd_en = !cmd_empty;
                if (!cmd_empty) begin
                    if (cmd_din == OPC_PING) begin
                        state_d = S_PING_RSP;
                    end else if (cmd_din == OPC_READ) begin
                        idx_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_ADDR: begin
                cmd_rd_en = !cmd_empty;
                if (!cmd_empty) begin
                    // Little-endian: the first address byte is the LSB.
                    addr_d[{idx_q, 3'b000} +: 8] = cmd_din;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_LEN;
                    end
                end
            end

            S_LEN: begin
                cmd_rd_en = !cmd_empty;
                if (!cmd_empty) begin
                    // A length byte of 0 encodes 256.
                    cnt_d   = (cmd_din == 8'h00) ? 9'd256 : {1'b0, cmd_din};
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                // Range check happens before any ROM access, so the word
                // address can never wrap.
                state_d = (addr_end > ROM_BYTES) ? S_ERR : S_HDR;
            end

            S_HDR: begin
                res_dout = RSP_READ_OK;
                if (!res_full) begin
                    res_wr_en = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_FETCH: begin
                rom_en   = 1'b1;
                rom_addr = addr_q[ROM_AW+2:3];
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                // ROM data arrives exactly one cycle after the strobe.
                word_d  = rom_rdata;
                state_d = S_SEND;
            end

            S_SEND: begin
                res_dout = lane_byte;
                if (!res_full) begin
                    res_wr_en = 1'b1;
                    addr_d    = addr_q + 32'd1;
                    cnt_d     = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = S_IDLE;
                    end else if (addr_q[2:0] == 3'b111) begin
                        // Crossed into the next word: fetch it.
                        state_d = S_FETCH;
                    end
                end
            end

            S_PING_RSP: begin
                res_dout = RSP_PING;
                if (!res_full) begin
                    res_wr_en = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_ERR: begin
                res_dout = RSP_ERR;
                if (!res_full) begin
                    res_wr_en = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held every output is quiet, so no byte is popped
        // or pushed on the cycle the engine is being cleared.
        if (rst) begin
            cmd_rd_en = 1'b0;
            res_wr_en = 1'b0;
            res_dout  = 8'h00;
            rom_en    = 1'b0;
            rom_addr  = '0;
        end
    end

    assign busy = (state_q != S_IDLE) && !rst;

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments
        // only, so every register samples the pre-edge value of the others.
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the word register is pure datapath and is always rewritten in
    // WAIT before SEND reads it, so it carries no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule : rom_cmd_engine

// File: tb/tb_rom_cmd_engine.sv
// ----------------------------------------------------------------------------
// tb_rom_cmd_engine
//   Self-checking bench for rom_cmd_engine. A command queue models the
//   first-word-fall-through command FIFO; expected response bytes are pushed
//   to a scoreboard queue as each command is queued and popped as the DUT
//   writes responses. The ROM model returns byte value (address & 0xFF).
// ----------------------------------------------------------------------------
module tb_rom_cmd_engine;

    localparam int ROM_AW = 12;
    localparam int DATA_W = 64;
    localparam int BUDGET = 5000;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_empty;
    logic [7:0]        cmd_din;
    logic              cmd_rd_en;
    logic              res_full;
    logic              res_wr_en;
    logic [7:0]        res_dout;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rdata = '0;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int viol_wr;
    int viol_rd;

    logic [7:0]        cmd_q[$];
    logic [7:0]        exp_q[$];
    logic [ROM_AW-1:0] rom_log[$];

    always #5 clk = ~clk;

    rom_cmd_engine #(
        .ROM_AW(ROM_AW),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_empty (cmd_empty),
        .cmd_din   (cmd_din),
        .cmd_rd_en (cmd_rd_en),
        .res_full  (res_full),
        .res_wr_en (res_wr_en),
        .res_dout  (res_dout),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .busy      (busy)
    );

    // ROM model: word i, lane k holds (8i+k) & 0xFF; data is only valid the
    // cycle after a strobe, otherwise a poison pattern.
    function automatic logic [63:0] rom_word(input logic [ROM_AW-1:0] wa);
        logic [63:0] w;
        logic [31:0] base;
        base = {17'd0, wa, 3'b000};
        for (int k = 0; k < 8; k++) begin
            w[8*k +: 8] = 8'((base + 32'(k)) & 32'hFF);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        rom_rdata <= rom_en ? rom_word(rom_addr) : 64'hDEAD_BEEF_0BAD_F00D;
    end

    // ------------------------------------------------------------------------
    // Stimulus / scoreboard helpers
    // ------------------------------------------------------------------------
    task automatic push_read_cmd(input logic [31:0] addr, input logic [7:0] len);
        cmd_q.push_back(8'h01);
        cmd_q.push_back(addr[7:0]);
        cmd_q.push_back(addr[15:8]);
        cmd_q.push_back(addr[23:16]);
        cmd_q.push_back(addr[31:24]);
        cmd_q.push_back(len);
    endtask

    task automatic push_read_exp(input logic [31:0] addr, input logic [7:0] len);
        int n;
        n = (len == 8'h00) ? 256 : int'(len);
        exp_q.push_back(8'hA1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'((addr + 32'(i)) & 32'hFF));
        end
    endtask

    function automatic bit rom_range_ok(input int first, input int n);
        if (rom_log.size() != n) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rom_log[i] !== ROM_AW'(first + i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Runs the FIFO models cycle by cycle until both queues are drained (plus
    // a few idle cycles to catch spurious pushes), or until stop_after
    // response bytes have been taken. Inputs change on the falling edge,
    // outputs are sampled 1 time unit later; returns just after a rising edge.
    task automatic drain(input string name, input bit bp, input int gap,
                         input int stop_after);
        int         cyc;
        int         gap_cnt;
        int         got;
        int         tail;
        bit         full_ph;
        logic [7:0] e;
        cyc = 0; gap_cnt = 0; got = 0; tail = 4; full_ph = 1'b0;
        viol_wr = 0;
        viol_rd = 0;
        rom_log.delete();
        forever begin
            if (stop_after >= 0 && got >= stop_after) break;
            if (cmd_q.size() == 0 && exp_q.size() == 0) begin
                if (tail == 0) break;
                tail--;
            end
            if (cyc >= BUDGET) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: %0d bytes pending, required 0", name,
                         exp_q.size());
                break;
            end
            cyc++;
            @(negedge clk);
            if (gap_cnt > 0) begin
                cmd_empty = 1'b1;
                gap_cnt--;
            end else begin
                cmd_empty = (cmd_q.size() == 0);
            end
            cmd_din  = (cmd_q.size() > 0) ? cmd_q[0] : 8'h00;
            res_full = bp ? full_ph : 1'b0;
            full_ph  = ~full_ph;
            #1;
            if (res_wr_en && res_full) viol_wr++;
            if (cmd_rd_en && cmd_empty) viol_rd++;
            if (rom_en) rom_log.push_back(rom_addr);
            if (res_wr_en) begin
                checks++;
                got++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected byte: got %02h, required none",
                             name, res_dout);
                end else begin
                    e = exp_q.pop_front();
                    if (res_dout !== e) begin
                        errors++;
                        $display("FAIL %s byte %0d: got %02h, required %02h",
                                 name, got - 1, res_dout, e);
                    end
                end
            end
            if (cmd_rd_en && !cmd_empty && cmd_q.size() > 0) begin
                void'(cmd_q.pop_front());
                gap_cnt = gap;
            end
            @(posedge clk);
        end
        cmd_empty = 1'b1;
        cmd_din   = 8'h00;
        res_full  = 1'b0;
        checks++;
        if (viol_wr !== 0) begin
            errors++;
            $display("FAIL %s res_wr_en while full: got %0d cycles, required 0",
                     name, viol_wr);
        end
        checks++;
        if (viol_rd !== 0) begin
            errors++;
            $display("FAIL %s cmd_rd_en while empty: got %0d cycles, required 0",
                     name, viol_rd);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        cmd_empty = 1'b1;
        cmd_din   = 8'h00;
        res_full  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %06h, required 000000",
                     {cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy} !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: got %06h, required 000000",
                     {cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy});
        end
        @(posedge clk);
    endtask

    task automatic test_ping();
        cmd_q.push_back(8'h02);
        exp_q.push_back(8'hA2);
        drain("ping", 1'b0, 0, -1);
        checks++;
        if (rom_log.size() !== 0) begin
            errors++;
            $display("FAIL ping_rom_en: got %0d pulses, required 0", rom_log.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ping_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_read_boundary();
        push_read_cmd(32'h0000_0005, 8'd4);
        push_read_exp(32'h0000_0005, 8'd4);
        drain("read_boundary", 1'b0, 0, -1);
        checks++;
        if (rom_range_ok(0, 2) !== 1'b1) begin
            errors++;
            $display("FAIL read_boundary_rom: got %0d pulses, required 2 (words 0,1)",
                     rom_log.size());
        end
    endtask

    task automatic test_read_len0();
        push_read_cmd(32'h0000_0000, 8'd0);
        push_read_exp(32'h0000_0000, 8'd0);
        drain("read_len0", 1'b0, 0, -1);
        checks++;
        if (rom_range_ok(0, 32) !== 1'b1) begin
            errors++;
            $display("FAIL read_len0_rom: got %0d pulses, required 32 (words 0..31)",
                     rom_log.size());
        end
    endtask

    task automatic test_range();
        // 0x7FFE + 4 runs past the end of the ROM.
        push_read_cmd(32'h0000_7FFE, 8'd4);
        exp_q.push_back(8'hEE);
        drain("range_over", 1'b0, 0, -1);
        checks++;
        if (rom_log.size() !== 0) begin
            errors++;
            $display("FAIL range_over_rom: got %0d pulses, required 0", rom_log.size());
        end
        // 0x7FFC + 4 ends exactly at the ROM size: legal.
        push_read_cmd(32'h0000_7FFC, 8'd4);
        push_read_exp(32'h0000_7FFC, 8'd4);
        drain("range_exact", 1'b0, 0, -1);
        checks++;
        if (rom_range_ok(12'hFFF, 1) !== 1'b1) begin
            errors++;
            $display("FAIL range_exact_rom: got %0d pulses, required 1 (word fff)",
                     rom_log.size());
        end
        // Non-zero high address bits always error.
        push_read_cmd(32'h0100_0000, 8'd1);
        exp_q.push_back(8'hEE);
        // Start address equal to the ROM size errors.
        push_read_cmd(32'h0000_8000, 8'd1);
        exp_q.push_back(8'hEE);
        cmd_q.push_back(8'h02);
        exp_q.push_back(8'hA2);
        drain("range_high", 1'b0, 0, -1);
        checks++;
        if (rom_log.size() !== 0) begin
            errors++;
            $display("FAIL range_high_rom: got %0d pulses, required 0", rom_log.size());
        end
    endtask

    task automatic test_back_to_back();
        // Boundary-crossing read with a toggling full flag and command gaps.
        push_read_cmd(32'h0000_0005, 8'd4);
        push_read_exp(32'h0000_0005, 8'd4);
        drain("backpressure", 1'b1, 3, -1);
        checks++;
        if (rom_range_ok(0, 2) !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_rom: got %0d pulses, required 2",
                     rom_log.size());
        end
        // Several frames queued with no gaps, mixed with backpressure.
        cmd_q.push_back(8'h02);
        exp_q.push_back(8'hA2);
        push_read_cmd(32'h0000_0123, 8'd11);
        push_read_exp(32'h0000_0123, 8'd11);
        cmd_q.push_back(8'h02);
        exp_q.push_back(8'hA2);
        drain("back_to_back", 1'b1, 0, -1);
        checks++;
        if (rom_range_ok(12'h024, 2) !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_rom: got %0d pulses, required 2",
                     rom_log.size());
        end
    endtask

    task automatic test_illegal_opcode();
        cmd_q.push_back(8'h55);
        exp_q.push_back(8'hEE);
        drain("illegal_opcode", 1'b0, 0, -1);
    endtask

    task automatic test_reset_mid_send();
        push_read_cmd(32'h0000_0000, 8'd16);
        push_read_exp(32'h0000_0000, 8'd16);
        drain("reset_mid_send", 1'b0, 0, 4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_send_busy: got %b, required 1", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_send_outputs: got %06h, required 000000",
                     {cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_send_idle: got %06h, required 000000",
                     {cmd_rd_en, res_wr_en, res_dout, rom_en, rom_addr, busy});
        end
        @(posedge clk);
        exp_q.delete();
        cmd_q.delete();
        cmd_q.push_back(8'h02);
        exp_q.push_back(8'hA2);
        drain("ping_after_reset", 1'b0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_ping();
        test_read_boundary();
        test_read_len0();
        test_range();
        test_back_to_back();
        test_illegal_opcode();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rom_cmd_engine
